// File: rtl/if_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : if_stage_pkg
//  Description : Shared CPU constants used by the instruction-fetch stage:
//                instruction width, the NOP encoding used to squash the
//                IF/ID register, and the default reset PC.
//  Revision    : 1.0 - initial release
// ============================================================================
package if_stage_pkg;

    localparam int INST_W = 32;

    // sll $0,$0,0 encodes as all zeros; used as the squashed-slot instruction.
    localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0000;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage : if_stage_pkg
`default_nettype wire

// File: rtl/if_stage_adder.sv
`default_nettype none
// ============================================================================
//  Module      : adder_32bits
//  Description : Plain 32-bit adder with carry in / carry out.
//                Ports: i_a, i_b (operands), i_ci (carry in),
//                       o_s (sum mod 2^32), o_co (carry out).
//  Revision    : 1.0 - initial release
// ============================================================================
module adder_32bits (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_ci,
    output logic [31:0] o_s,
    output logic        o_co
);

    logic [32:0] w_sum;

    assign w_sum = {1'b0, i_a} + {1'b0, i_b} + {32'b0, i_ci};
    assign o_s   = w_sum[31:0];
    assign o_co  = w_sum[32];

endmodule : adder_32bits
`default_nettype wire

// File: rtl/if_stage_instruction_rom.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_rom
//  Description : Word-addressed instruction ROM with asynchronous read.
//                Contents are preloaded externally into the memory array.
//                Ports: i_addr (word address), o_data (instruction word).
//  Revision    : 1.0 - initial release
// ============================================================================
module instruction_rom
    import if_stage_pkg::*;
#(
    parameter int    IMEM_AW   = 8,
    parameter string IMEM_INIT = "inst.hex"
) (
    input  logic [IMEM_AW-1:0] i_addr,
    output logic [INST_W-1:0]  o_data
);

    localparam int DEPTH = 1 << IMEM_AW;

    logic [INST_W-1:0] r_mem [0:DEPTH-1];

    assign o_data = r_mem[i_addr];

endmodule : instruction_rom
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
//  Module      : if_stage
//  Description : Instruction-fetch stage. Owns the PC, reads the instruction
//                ROM and holds the IF/ID register. Decode-stage redirects
//                (JR > J > taken branch) squash the wrong-path fetch; the
//                load-use stall (PC_IFWrite=0) freezes PC and IF/ID.
//                Ports:
//                  clk, reset        - clock, synchronous active-high reset
//                  PC_IFWrite        - 1 = update, 0 = hold
//                  Z, J, JR          - redirect requests from ID
//                  BranchAddr, JumpAddr, JrAddr - redirect targets
//                  PC_if             - current fetch PC
//                  Instruction_id, NextPC_id, Valid_id - IF/ID register
//  Revision    : 1.0 - initial release
// ============================================================================
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int          IMEM_AW   = 8,
    parameter string       IMEM_INIT = "inst.hex"
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              PC_IFWrite,
    input  logic              Z,
    input  logic              J,
    input  logic              JR,
    input  logic [31:0]       BranchAddr,
    input  logic [31:0]       JumpAddr,
    input  logic [31:0]       JrAddr,
    output logic [31:0]       PC_if,
    output logic [INST_W-1:0] Instruction_id,
    output logic [31:0]       NextPC_id,
    output logic              Valid_id
);

    logic [31:0]       r_pc_q;
    logic [31:0]       w_pc_d;
    logic [INST_W-1:0] r_inst_q;
    logic [INST_W-1:0] w_inst_d;
    logic [31:0]       r_npc_q;
    logic [31:0]       w_npc_d;
    logic              r_valid_q;
    logic              w_valid_d;

    logic [INST_W-1:0] w_instr_if;
    logic [31:0]       w_next_pc_if;
    logic              w_unused_co;
    logic              w_redirect;
    logic [31:0]       w_target;

    // PC bits [1:0] ignored; upper bits dropped so the index wraps.
    instruction_rom #(
        .IMEM_AW   (IMEM_AW),
        .IMEM_INIT (IMEM_INIT)
    ) u_rom (
        .i_addr (r_pc_q[IMEM_AW+1:2]),
        .o_data (w_instr_if)
    );

    adder_32bits u_pc_add (
        .i_a  (r_pc_q),
        .i_b  (32'd4),
        .i_ci (1'b0),
        .o_s  (w_next_pc_if),
        .o_co (w_unused_co)
    );

    assign w_redirect = JR | J | Z;

    always_comb begin
        w_target = BranchAddr;
        if (JR) begin
            w_target = JrAddr;
        end else if (J) begin
            w_target = JumpAddr;
        end
    end

    always_comb begin
        w_pc_d    = r_pc_q;
        w_inst_d  = r_inst_q;
        w_npc_d   = r_npc_q;
        w_valid_d = r_valid_q;
        // Under a stall the redirect inputs may be built from stale operands,
        // so they are ignored entirely; decode re-presents them next cycle.
        if (PC_IFWrite) begin
            if (w_redirect) begin
                w_pc_d    = w_target;
                w_inst_d  = NOP_INST;
                w_npc_d   = 32'h0;
                w_valid_d = 1'b0;
            end else begin
                w_pc_d    = w_next_pc_if;
                w_inst_d  = w_instr_if;
                w_npc_d   = w_next_pc_if;
                w_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc_q    <= RESET_PC;
            r_inst_q  <= NOP_INST;
            r_npc_q   <= 32'h0;
            r_valid_q <= 1'b0;
        end else begin
            r_pc_q    <= w_pc_d;
            r_inst_q  <= w_inst_d;
            r_npc_q   <= w_npc_d;
            r_valid_q <= w_valid_d;
        end
    end

    assign PC_if          = r_pc_q;
    assign Instruction_id = r_inst_q;
    assign NextPC_id      = r_npc_q;
    assign Valid_id       = r_valid_q;

endmodule : if_stage
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_stage
//  Description : Self-checking bench for if_stage. Each scenario task queues
//                its stimulus, pushes the expected IF state per edge into a
//                scoreboard, then pops and compares after every edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_if_stage;

    localparam int AW = 5;   // 32-word ROM: 0x40 -> word 16, 0x80 wraps to word 0

    logic        clk = 1'b0;
    logic        reset;
    logic        PC_IFWrite;
    logic        Z, J, JR;
    logic [31:0] BranchAddr, JumpAddr, JrAddr;
    logic [31:0] PC_if, Instruction_id, NextPC_id;
    logic        Valid_id;

    typedef struct {
        logic        r, we, z, j, jr;
        logic [31:0] ba, ja, jra;
    } stim_t;

    typedef struct {
        logic [31:0] pc, inst, npc;
        logic        valid;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    if_stage #(
        .RESET_PC  (32'h0),
        .IMEM_AW   (AW),
        .IMEM_INIT ("")
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .PC_IFWrite     (PC_IFWrite),
        .Z              (Z),
        .J              (J),
        .JR             (JR),
        .BranchAddr     (BranchAddr),
        .JumpAddr       (JumpAddr),
        .JrAddr         (JrAddr),
        .PC_if          (PC_if),
        .Instruction_id (Instruction_id),
        .NextPC_id      (NextPC_id),
        .Valid_id       (Valid_id)
    );

    function automatic logic [31:0] rom_word(input int idx);
        return 32'hC0DE_0000 + 32'h0000_0101 * idx + 32'd1;
    endfunction

    function automatic stim_t mk(input logic r, we, z, j, jr,
                                 input logic [31:0] ba, ja, jra);
        stim_t s;
        s.r = r; s.we = we; s.z = z; s.j = j; s.jr = jr;
        s.ba = ba; s.ja = ja; s.jra = jra;
        return s;
    endfunction

    function automatic stim_t run();
        return mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    endfunction

    function automatic exp_t ex(input logic [31:0] pc, inst, npc, input logic v);
        exp_t e;
        e.pc = pc; e.inst = inst; e.npc = npc; e.valid = v;
        return e;
    endfunction

    // Drives one cycle's inputs on the falling edge and returns just after
    // the next rising edge, where outputs are stable for sampling.
    task automatic step(input stim_t s);
        @(negedge clk);
        reset = s.r; PC_IFWrite = s.we; Z = s.z; J = s.j; JR = s.jr;
        BranchAddr = s.ba; JumpAddr = s.ja; JrAddr = s.jra;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0));
    endtask

    task automatic test_reset();
        stim_t st[$];
        exp_t  e;
        st.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0));
        sb.push_back(ex(32'h0, 32'h0, 32'h0, 1'b0));
        st.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h40, 32'h80, 32'h100));
        sb.push_back(ex(32'h0, 32'h0, 32'h0, 1'b0));
        foreach (st[i]) begin
            step(st[i]);
            e = sb.pop_front();
            n_tests++;
            if (PC_if !== e.pc || Instruction_id !== e.inst ||
                NextPC_id !== e.npc || Valid_id !== e.valid) begin
                n_fail++;
                $display("FAIL reset[%0d]: got pc=%h inst=%h npc=%h v=%b, expected pc=%h inst=%h npc=%h v=%b",
                         i, PC_if, Instruction_id, NextPC_id, Valid_id, e.pc, e.inst, e.npc, e.valid);
            end
        end
    endtask

    task automatic test_free_run();
        stim_t st[$];
        exp_t  e;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            st.push_back(run());
            sb.push_back(ex(32'(4 * (k + 1)), rom_word(k), 32'(4 * (k + 1)), 1'b1));
        end
        foreach (st[i]) begin
            step(st[i]);
            e = sb.pop_front();
            n_tests++;
            if (PC_if !== e.pc || Instruction_id !== e.inst ||
                NextPC_id !== e.npc || Valid_id !== e.valid) begin
                n_fail++;
                $display("FAIL free_run[%0d]: got pc=%h inst=%h npc=%h v=%b, expected pc=%h inst=%h npc=%h v=%b",
                         i, PC_if, Instruction_id, NextPC_id, Valid_id, e.pc, e.inst, e.npc, e.valid);
            end
        end
    endtask

    task automatic test_branch();
        stim_t st[$];
        exp_t  e;
        do_reset();
        st.push_back(run()); sb.push_back(ex(32'h4, rom_word(0), 32'h4, 1'b1));
        st.push_back(run()); sb.push_back(ex(32'h8, rom_word(1), 32'h8, 1'b1));
        st.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0));
        sb.push_back(ex(32'h40, 32'h0, 32'h0, 1'b0));
        st.push_back(run()); sb.push_back(ex(32'h44, rom_word(16), 32'h44, 1'b1));
        foreach (st[i]) begin
            step(st[i]);
            e = sb.pop_front();
            n_tests++;
            if (PC_if !== e.pc || Instruction_id !== e.inst ||
                NextPC_id !== e.npc || Valid_id !== e.valid) begin
                n_fail++;
                $display("FAIL branch[%0d]: got pc=%h inst=%h npc=%h v=%b, expected pc=%h inst=%h npc=%h v=%b",
                         i, PC_if, Instruction_id, NextPC_id, Valid_id, e.pc, e.inst, e.npc, e.valid);
            end
        end
    endtask

    task automatic test_jump_priority();
        stim_t st[$];
        exp_t  e;
        do_reset();
        // JR beats J
        st.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h40, 32'h80, 32'h100));
        sb.push_back(ex(32'h100, 32'h0, 32'h0, 1'b0));
        st.push_back(run()); sb.push_back(ex(32'h104, rom_word(0), 32'h104, 1'b1));
        // J beats Z
        st.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h40, 32'h88, 32'h100));
        sb.push_back(ex(32'h88, 32'h0, 32'h0, 1'b0));
        st.push_back(run()); sb.push_back(ex(32'h8C, rom_word(2), 32'h8C, 1'b1));
        // JR beats Z
        st.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h40, 32'h88, 32'h14));
        sb.push_back(ex(32'h14, 32'h0, 32'h0, 1'b0));
        st.push_back(run()); sb.push_back(ex(32'h18, rom_word(5), 32'h18, 1'b1));
        foreach (st[i]) begin
            step(st[i]);
            e = sb.pop_front();
            n_tests++;
            if (PC_if !== e.pc || Instruction_id !== e.inst ||
                NextPC_id !== e.npc || Valid_id !== e.valid) begin
                n_fail++;
                $display("FAIL jump_prio[%0d]: got pc=%h inst=%h npc=%h v=%b, expected pc=%h inst=%h npc=%h v=%b",
                         i, PC_if, Instruction_id, NextPC_id, Valid_id, e.pc, e.inst, e.npc, e.valid);
            end
        end
    endtask

    task automatic test_stall();
        stim_t st[$];
        exp_t  e;
        do_reset();
        step(run());
        step(run());
        // PC=8, IF/ID holds word 1; stall with a branch request present
        for (int k = 0; k < 2; k++) begin
            st.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0));
            sb.push_back(ex(32'h8, rom_word(1), 32'h8, 1'b1));
        end
        st.push_back(run()); sb.push_back(ex(32'hC, rom_word(2), 32'hC, 1'b1));
        st.push_back(run()); sb.push_back(ex(32'h10, rom_word(3), 32'h10, 1'b1));
        foreach (st[i]) begin
            step(st[i]);
            e = sb.pop_front();
            n_tests++;
            if (PC_if !== e.pc || Instruction_id !== e.inst ||
                NextPC_id !== e.npc || Valid_id !== e.valid) begin
                n_fail++;
                $display("FAIL stall[%0d]: got pc=%h inst=%h npc=%h v=%b, expected pc=%h inst=%h npc=%h v=%b",
                         i, PC_if, Instruction_id, NextPC_id, Valid_id, e.pc, e.inst, e.npc, e.valid);
            end
        end
    endtask

    task automatic test_back_to_back();
        stim_t st[$];
        exp_t  e;
        do_reset();
        step(run());
        st.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h88, 32'h0));
        sb.push_back(ex(32'h88, 32'h0, 32'h0, 1'b0));
        st.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h104));
        sb.push_back(ex(32'h104, 32'h0, 32'h0, 1'b0));
        st.push_back(run()); sb.push_back(ex(32'h108, rom_word(1), 32'h108, 1'b1));
        foreach (st[i]) begin
            step(st[i]);
            e = sb.pop_front();
            n_tests++;
            if (PC_if !== e.pc || Instruction_id !== e.inst ||
                NextPC_id !== e.npc || Valid_id !== e.valid) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: got pc=%h inst=%h npc=%h v=%b, expected pc=%h inst=%h npc=%h v=%b",
                         i, PC_if, Instruction_id, NextPC_id, Valid_id, e.pc, e.inst, e.npc, e.valid);
            end
        end
    endtask

    task automatic test_reset_priority();
        stim_t st[$];
        exp_t  e;
        do_reset();
        st.push_back(run()); sb.push_back(ex(32'h4, rom_word(0), 32'h4, 1'b1));
        st.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0));
        sb.push_back(ex(32'h0, 32'h0, 32'h0, 1'b0));
        st.push_back(run()); sb.push_back(ex(32'h4, rom_word(0), 32'h4, 1'b1));
        st.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0));
        sb.push_back(ex(32'h0, 32'h0, 32'h0, 1'b0));
        foreach (st[i]) begin
            step(st[i]);
            e = sb.pop_front();
            n_tests++;
            if (PC_if !== e.pc || Instruction_id !== e.inst ||
                NextPC_id !== e.npc || Valid_id !== e.valid) begin
                n_fail++;
                $display("FAIL reset_prio[%0d]: got pc=%h inst=%h npc=%h v=%b, expected pc=%h inst=%h npc=%h v=%b",
                         i, PC_if, Instruction_id, NextPC_id, Valid_id, e.pc, e.inst, e.npc, e.valid);
            end
        end
    endtask

    task automatic test_wrap();
        stim_t st[$];
        exp_t  e;
        do_reset();
        st.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'hFFFF_FFFC));
        sb.push_back(ex(32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0));
        st.push_back(run()); sb.push_back(ex(32'h0, rom_word(31), 32'h0, 1'b1));
        // 4 * 2^AW = 0x80 must fetch word 0
        st.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h80, 32'h0));
        sb.push_back(ex(32'h80, 32'h0, 32'h0, 1'b0));
        st.push_back(run()); sb.push_back(ex(32'h84, rom_word(0), 32'h84, 1'b1));
        foreach (st[i]) begin
            step(st[i]);
            e = sb.pop_front();
            n_tests++;
            if (PC_if !== e.pc || Instruction_id !== e.inst ||
                NextPC_id !== e.npc || Valid_id !== e.valid) begin
                n_fail++;
                $display("FAIL wrap[%0d]: got pc=%h inst=%h npc=%h v=%b, expected pc=%h inst=%h npc=%h v=%b",
                         i, PC_if, Instruction_id, NextPC_id, Valid_id, e.pc, e.inst, e.npc, e.valid);
            end
        end
    endtask

    initial begin
        reset = 1'b1; PC_IFWrite = 1'b1; Z = 1'b0; J = 1'b0; JR = 1'b0;
        BranchAddr = 32'h0; JumpAddr = 32'h0; JrAddr = 32'h0;
        for (int i = 0; i < (1 << AW); i++) begin
            dut.u_rom.r_mem[i] = rom_word(i);
        end
        test_reset();
        test_free_run();
        test_branch();
        test_jump_priority();
        test_stall();
        test_back_to_back();
        test_reset_priority();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_if_stage
`default_nettype wire
